// File: rtl/serial_add_seq_pkg.sv
// Shared types and constants for the byte-serial adder sequencer.
// Holds the FSM encoding and the byte-counter sizing helper.
package serial_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_add_adder8.sv
// Combinational 8-bit adder with carry in/out.
// Paired with serial_add_seq one level up.
module serial_add_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    assign {cout, s} = 9'(a) + 9'(b) + 9'(cin);

endmodule

// File: rtl/serial_add_top.sv
// Sequencer paired with one 8-bit adder: a W-bit serial adder.
// The adder return path is purely combinational.
module serial_add_top
    import serial_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    input  logic [BYTE_W*NBYTES-1:0]   op_a,
    input  logic [BYTE_W*NBYTES-1:0]   op_b,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [BYTE_W*NBYTES-1:0]   sum,
    output logic                       cout
);

    logic [BYTE_W-1:0] add_a;
    logic [BYTE_W-1:0] add_b;
    logic [BYTE_W-1:0] add_s;
    logic              add_cin;
    logic              add_cout;

    serial_add_seq #(.NBYTES(NBYTES)) u_seq (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    serial_add_adder8 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

endmodule

// File: rtl/serial_add_seq.sv
// Byte-serial sequencer: drives an external 8-bit adder LSB first,
// rippling carry between bytes, and registers the wide result.
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    input  logic [BYTE_W*NBYTES-1:0]   op_a,
    input  logic [BYTE_W*NBYTES-1:0]   op_b,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [BYTE_W*NBYTES-1:0]   sum,
    output logic                       cout,
    output logic [BYTE_W-1:0]          add_a,
    output logic [BYTE_W-1:0]          add_b,
    output logic                       add_cin,
    input  logic [BYTE_W-1:0]          add_s,
    input  logic                       add_cout
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int CW = cnt_width(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   s_sh;
    logic [W-1:0]   s_nx;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           run;
    logic           accept;
    logic           last;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                accept   = start;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign run  = (state == RUN);
    assign busy = run;
    assign done = (state == DONE);

    // Adder inputs come straight from the shift registers: no added latency.
    assign add_a   = run ? a_sh[BYTE_W-1:0] : '0;
    assign add_b   = run ? b_sh[BYTE_W-1:0] : '0;
    assign add_cin = run & carry;

    assign s_nx = W'({add_s, s_sh} >> BYTE_W);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sh  <= op_a;
                b_sh  <= op_b;
                carry <= cin;
                cnt   <= '0;
            end else if (run) begin
                a_sh  <= a_sh >> BYTE_W;
                b_sh  <= b_sh >> BYTE_W;
                s_sh  <= s_nx;
                carry <= add_cout;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum  <= s_nx;
                    cout <= add_cout;
                end
            end
        end
    end

endmodule
